// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the pipelined CPU: sequencer states and stall-cause codes.
// Pure declarations; no logic, no latency, no flow control.
package cpu_ctrl_pkg;

    localparam int CPU_ADDR_BITS = 3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } hazard_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_MEM     = 2'd1,
        CAUSE_LOADUSE = 2'd2,
        CAUSE_HALT    = 2'd3
    } stall_cause_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still sitting in EX.
// Combinational, zero latency; no flow control of its own.
module load_use_detect #(
    parameter int AddrBits = cpu_ctrl_pkg::CPU_ADDR_BITS,
    parameter bit R0IsZero = 1'b1
) (
    input  logic [AddrBits-1:0] reg_a,
    input  logic [AddrBits-1:0] reg_b,
    input  logic                uses_a,
    input  logic                uses_b,
    input  logic                ex_mem_read,
    input  logic [AddrBits-1:0] ex_dest_reg,
    output logic                hit
);

    logic match_a;
    logic match_b;
    logic dest_is_r0;

    assign match_a    = uses_a && (reg_a == ex_dest_reg);
    assign match_b    = uses_b && (reg_b == ex_dest_reg);
    assign dest_is_r0 = (ex_dest_reg == '0);

    // Register 0 is hard-wired when R0IsZero, so a load into it produces nothing to wait for.
    assign hit = ex_mem_read && (match_a || match_b) && !(R0IsZero && dest_is_r0);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: memory freeze > taken branch > load-use, plus a memory-timeout watchdog.
// Mealy outputs (zero latency from inputs); HALT freezes everything until RST.
module pipeline_hazard_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int AddrBits = CPU_ADDR_BITS,
    parameter int MaxWait  = 4,
    parameter int CntWidth = 16,
    parameter bit R0IsZero = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [AddrBits-1:0] IF_ID_RegA,
    input  logic [AddrBits-1:0] IF_ID_RegB,
    input  logic                IF_ID_UsesA,
    input  logic                IF_ID_UsesB,
    input  logic                ID_EX_MemRead,
    input  logic [AddrBits-1:0] ID_EX_DestReg,
    input  logic                EX_BranchTaken,
    input  logic                EX_MEM_MemAccess,
    input  logic                Mem_Ready,
    output logic                PC_Write,
    output logic                IF_ID_Write,
    output logic                IF_ID_Flush,
    output logic                ID_EX_Write,
    output logic                ID_EX_Flush,
    output logic                EX_MEM_Write,
    output logic                MEM_WB_Bubble,
    output logic [1:0]          Stall_Cause,
    output logic                Mem_Timeout,
    output logic [CntWidth-1:0] StallCycles
);

    localparam int WaitBits = $clog2(MaxWait + 1);
    localparam logic [WaitBits-1:0] WaitLast = WaitBits'(MaxWait - 1);

    hazard_state_t       state;
    hazard_state_t       state_nxt;
    logic [WaitBits-1:0] wait_cnt;
    logic [WaitBits-1:0] wait_cnt_nxt;
    logic [CntWidth-1:0] stall_cnt;
    stall_cause_t        cause;
    logic                freeze;
    logic                load_use_hit;

    assign freeze = EX_MEM_MemAccess && !Mem_Ready;

    load_use_detect #(
        .AddrBits (AddrBits),
        .R0IsZero (R0IsZero)
    ) u_load_use_detect (
        .reg_a       (IF_ID_RegA),
        .reg_b       (IF_ID_RegB),
        .uses_a      (IF_ID_UsesA),
        .uses_b      (IF_ID_UsesB),
        .ex_mem_read (ID_EX_MemRead),
        .ex_dest_reg (ID_EX_DestReg),
        .hit         (load_use_hit)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        PC_Write      = 1'b0;
        IF_ID_Write   = 1'b0;
        IF_ID_Flush   = 1'b0;
        ID_EX_Write   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Write  = 1'b0;
        MEM_WB_Bubble = 1'b0;
        Mem_Timeout   = 1'b0;
        cause         = CAUSE_NONE;

        // Outputs must read as reset values for as long as RST is high, not just after an edge.
        if (!RST) begin
            unique case (state)
                ST_RUN: begin
                    wait_cnt_nxt = '0;
                    if (freeze) begin
                        MEM_WB_Bubble = 1'b1;
                        cause         = CAUSE_MEM;
                        wait_cnt_nxt  = wait_cnt + WaitBits'(1);
                        if (wait_cnt == WaitLast) begin
                            state_nxt = ST_HALT;
                        end
                    end else begin
                        PC_Write     = 1'b1;
                        IF_ID_Write  = 1'b1;
                        ID_EX_Write  = 1'b1;
                        EX_MEM_Write = 1'b1;
                        if (EX_BranchTaken) begin
                            // The ID instruction is discarded anyway, so a load-use hit is moot.
                            IF_ID_Flush = 1'b1;
                            ID_EX_Flush = 1'b1;
                        end else if (load_use_hit) begin
                            PC_Write    = 1'b0;
                            IF_ID_Write = 1'b0;
                            ID_EX_Flush = 1'b1;
                            cause       = CAUSE_LOADUSE;
                        end
                    end
                end
                ST_HALT: begin
                    MEM_WB_Bubble = 1'b1;
                    Mem_Timeout   = 1'b1;
                    cause         = CAUSE_HALT;
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign Stall_Cause = cause;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if ((state == ST_RUN) && !PC_Write && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CntWidth'(1);
        end
    end

    assign StallCycles = stall_cnt;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 16-bit, 8-register pipelined CPU. It drives the write enables and flushes of the PC, IF_ID, ID_EX and EX_MEM registers, and the bubble into MEM_WB. It resolves three events: data-memory wait, taken branch and load-use hazard. It also runs a memory-timeout watchdog and a saturating stall-cycle counter.

Parameters:
AddrBits, 3, register-address width (8 registers)
MaxWait, 4, consecutive memory-freeze cycles before timeout halt (>=1)
CntWidth, 16, StallCycles counter width
R0IsZero, 1, when 1 a load to register 0 never causes a load-use stall

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
IF_ID_RegA  in  AddrBits  source A of the instruction in ID
IF_ID_RegB  in  AddrBits  source B of the instruction in ID
IF_ID_UsesA  in  1  ID instruction reads RegA
IF_ID_UsesB  in  1  ID instruction reads RegB
ID_EX_MemRead  in  1  instruction in EX is a load
ID_EX_DestReg  in  AddrBits  destination of the instruction in EX
EX_BranchTaken  in  1  branch resolved taken in EX this cycle
EX_MEM_MemAccess  in  1  instruction in MEM accesses data memory
Mem_Ready  in  1  data memory completes the access this cycle
PC_Write  out  1  PC load enable
IF_ID_Write  out  1  IF_ID load enable
IF_ID_Flush  out  1  IF_ID loads a NOP
ID_EX_Write  out  1  ID_EX load enable
ID_EX_Flush  out  1  ID_EX loads a NOP (zero control)
EX_MEM_Write  out  1  EX_MEM load enable
MEM_WB_Bubble  out  1  MEM_WB loads zero control
Stall_Cause  out  2  0 none, 1 memory, 2 load-use, 3 halt
Mem_Timeout  out  1  sticky watchdog flag
StallCycles  out  CntWidth  saturating count of cycles with PC_Write=0

Behaviour:
- States: RUN and HALT. Registers: state, WaitCnt (width ceil(log2(MaxWait+1))) and StallCycles. Outputs are Mealy: decoded from state plus current inputs, with zero latency.
- While RST=1: state=RUN, WaitCnt=0, StallCycles=0, Mem_Timeout=0, Stall_Cause=0, and all enables, flushes and bubble are 0.
- Default decode in RUN with no event: PC_Write, IF_ID_Write, ID_EX_Write and EX_MEM_Write are 1; both flushes and the bubble are 0.
- Event priority in RUN, highest first:
  1. Freeze (EX_MEM_MemAccess=1 and Mem_Ready=0). All write enables are 0, both flushes are 0, MEM_WB_Bubble=1, Stall_Cause=1. Freeze overrides branch and load-use. EX is held, so EX_BranchTaken is presented again on the cycle the freeze releases.
  2. Branch (EX_BranchTaken=1). IF_ID_Flush=1 and ID_EX_Flush=1; all enables stay 1. Branch overrides load-use because the ID instruction is discarded.
  3. Load-use. Hit when ID_EX_MemRead=1 and ID_EX_DestReg matches a used source (UsesA with RegA, or UsesB with RegB). When R0IsZero=1 and ID_EX_DestReg=0 there is no hit. On a hit: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, EX_MEM_Write=1, Stall_Cause=2. The stall lasts exactly one cycle because the load then leaves EX.
- WaitCnt:
  - increments on every freeze cycle and clears on any non-freeze cycle;
  - if a freeze cycle occurs with WaitCnt=MaxWait-1, the next state is HALT;
  - MaxWait consecutive freeze cycles therefore halt; MaxWait-1 cycles do not.
- HALT: all enables 0, flushes 0, MEM_WB_Bubble=1, Stall_Cause=3, Mem_Timeout=1. Inputs are ignored. HALT is exited only by RST.
- StallCycles:
  - increments at each clock edge where state=RUN and PC_Write=0;
  - saturates at all-ones with no wrap;
  - is frozen in HALT.
- RST asserted mid-freeze or mid-stall: takes effect immediately (asynchronous), and the first cycle after release is a normal RUN cycle.

Decomposition:
- Package cpu_ctrl_pkg holds the state encoding (RUN=0, HALT=1) and the Stall_Cause codes (CAUSE_NONE, CAUSE_MEM, CAUSE_LOADUSE, CAUSE_HALT). AddrBits stays consistent with the other CPU stage registers.
- One combinational sub-module, load_use_detect, computes the load-use hit and honours R0IsZero. All priority, state and counter logic stays in the top module.

Test Plan:
- Reset then idle inputs: all enables=1, flushes=0, Stall_Cause=0, StallCycles=0. Assert RST mid-run: outputs go to the reset values immediately, without waiting for a clock edge.
- ID_EX_MemRead=1, ID_EX_DestReg=5, IF_ID_RegB=5, UsesB=1 for one cycle: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, Stall_Cause=2, StallCycles 0->1. Repeat with DestReg=0: no stall.
- EX_BranchTaken=1 together with a load-use hit: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, Stall_Cause=0.
- EX_MEM_MemAccess=1, Mem_Ready=0 for 3 cycles, then Mem_Ready=1 (MaxWait=4): frozen 3 cycles with MEM_WB_Bubble=1, no timeout, StallCycles=3. A branch held during the freeze flushes only on the release cycle.
- Mem_Ready=0 for 4 cycles (MaxWait=4): after the 4th edge Mem_Timeout=1 and Stall_Cause=3. Outputs stay frozen despite input changes until RST.
- Force 2^CntWidth+2 stall cycles (CntWidth=4 build): StallCycles holds at 15.
